// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V front end.
//   XLEN          : machine word width.
//   RV_NOP        : canonical NOP encoding (addi x0, x0, 0).
//   fetch_state_e : fetch controller states (BOOT, RUN, FLUSH).
//   fetch_entry_t : one buffered fetch result {data, pc, misaligned}.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RV_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] data;
        logic [XLEN-1:0] pc;
        logic            misaligned;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO used by the fetch unit for both the instruction
// buffer and the PC tag queue.
// Parameters: WIDTH (entry width), DEPTH (entries, power of two >= 2).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset.
//   flush      : synchronous clear; a push in the same cycle survives as the
//                only entry.
//   push/wdata : write an entry (caller guarantees no overflow).
//   pop        : drop the head entry (caller guarantees non-empty).
//   rdata      : head entry.
//   count      : number of stored entries.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int WIDTH = XLEN,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]      count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            if (push) begin
                mem_d[0] = wdata;
                wr_ptr_d = AW'(1);
                count_d  = {{AW{1'b0}}, 1'b1};
            end
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order word requests to
// instruction memory, buffers returned words with their PCs and hands them
// to decode. A redirect flushes buffered work and drops responses that were
// already in flight.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (adds inst_misaligned; a
// misaligned redirect emits one NOP entry flagged misaligned and halts fetch
// until the next redirect).
// Ports:
//   clk, rst_n                      : clock, async active-low reset.
//   imem_req_valid/ready/addr       : request channel to instruction memory.
//   imem_rsp_valid/data             : in-order responses, always accepted.
//   redirect_valid/pc               : one-cycle PC redirect.
//   inst_valid/ready/data/pc        : decode channel.
//   inst_misaligned                 : (FETCH_MISALIGN_TRAP_EN only).
// Handshakes: a transfer happens on a cycle where valid and ready are both
// high; valid never depends on ready and the payload is held while valid is
// high and ready is low.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic            inst_misaligned
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   stale_q, stale_d;

    // The tag queue occupancy is the count of live outstanding requests.
    logic [CW-1:0]   tag_count;
    logic [XLEN-1:0] tag_head;
    logic [CW-1:0]   fifo_count;
    fetch_entry_t    fifo_head, fifo_wdata;
    logic            fifo_push, fifo_pop;
    logic            req_fire, rsp_live, redir_misaligned, fetch_halted;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic halt_q, halt_d;
    assign redir_misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign halt_d           = redirect_valid ? redir_misaligned : halt_q;
    assign fetch_halted     = halt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) halt_q <= 1'b0;
        else        halt_q <= halt_d;
    end
`else
    assign redir_misaligned = 1'b0;
    assign fetch_halted     = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        stale_d        = stale_q;
        imem_req_valid = 1'b0;

        // Credit counts only what is already in flight or buffered; a pop
        // this cycle frees its slot from the next cycle on.
        if (state_q == RUN && !redirect_valid && !fetch_halted) begin
            imem_req_valid = ({1'b0, tag_count} + {1'b0, fifo_count}) < DEPTH_W;
        end
        req_fire = imem_req_valid && imem_req_ready;
        rsp_live = imem_rsp_valid && (stale_q == '0) && !redirect_valid;

        if (req_fire) begin
            pc_d = pc_q + 32'd4;
        end
        if (imem_rsp_valid && (stale_q != '0)) begin
            stale_d = stale_q - 1'b1;
        end

        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     state_d = RUN;
            FLUSH:   if (stale_d == '0) state_d = RUN;
            default: state_d = BOOT;
        endcase

        // Everything still in flight becomes stale; a response arriving in
        // the redirect cycle is one of those and is already gone.
        if (redirect_valid) begin
            stale_d = stale_q + tag_count - {{(CW-1){1'b0}}, imem_rsp_valid};
            pc_d    = redirect_pc & ~32'h0000_0003;
            state_d = (stale_d != '0) ? FLUSH : RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            stale_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            stale_q <= stale_d;
        end
    end

    assign imem_req_addr = pc_q;

    fetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_tag_q (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect_valid),
        .push  (req_fire),
        .wdata (pc_q),
        .pop   (rsp_live),
        .rdata (tag_head),
        .count (tag_count)
    );

    // The trap entry carries no fetched word; the NOP is substituted on the
    // way out so the buffer only needs the flag.
    always_comb begin
        fifo_wdata.data       = redir_misaligned ? '0 : imem_rsp_data;
        fifo_wdata.pc         = redir_misaligned ? redirect_pc : tag_head;
        fifo_wdata.misaligned = redir_misaligned;
    end

    assign fifo_push = rsp_live || redir_misaligned;
    assign fifo_pop  = inst_valid && inst_ready;

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_inst_q (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect_valid),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .count (fifo_count)
    );

    assign inst_valid = (fifo_count != '0);

    always_comb begin
        inst_data = '0;
        inst_pc   = '0;
        if (inst_valid) begin
            inst_data = fifo_head.misaligned ? RV_NOP : fifo_head.data;
            inst_pc   = fifo_head.pc;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    assign inst_misaligned = inst_valid && fifo_head.misaligned;
`endif

    // A response nobody asked for means the memory and fetch disagree.
    rsp_tracked: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rsp_valid |-> ((tag_count != '0) || (stale_q != '0)));

endmodule
